alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
// - Initiator side of the 8-bit ALU operand/opcode interface: accepts ALU commands on a
//   valid/ready stream, queues them, drives A/B/ALU_Sel to a combinational ALU, captures
//   ALU_Out/CarryOut and returns tagged results on a valid/ready response stream.
// - Sits between a command source and the combinational ALU; serialises commands in order.
// PARAMETERS
// - DEPTH  4  command FIFO entries (power of 2, >=2)
// - TAG_W  4  width of command tag returned with each result
// PORTS
// - clk          in   1      clock; all state on rising edge
// - rst          in   1      synchronous reset, active-high
// - cmd_valid    in   1      command present
// - cmd_ready    out  1      FIFO can accept command
// - cmd_op       in   4      opcode: 0000 add, 0001 sub, 0010 and, 0011 xor
// - cmd_a        in   8      operand A
// - cmd_b        in   8      operand B
// - cmd_tag      in   TAG_W  tag echoed on response
// - alu_a        out  8      registered operand A to ALU
// - alu_b        out  8      registered operand B to ALU
// - alu_sel      out  4      registered opcode to ALU
// - alu_out      in   8      ALU result (combinational from alu_a/alu_b/alu_sel)
// - alu_carry    in   1      ALU carry (carry of A+B, independent of opcode)
// - rsp_valid    out  1      response present
// - rsp_ready    in   1      response consumed
// - rsp_data     out  8      captured result
// - rsp_carry    out  1      alu_carry if opcode 0000, else 0
// - rsp_illegal  out  1      opcode > 4'b0011 (ALU default path, A-B)
// - rsp_tag      out  TAG_W  tag of the command
// BEHAVIOUR
// - Reset: FIFO empty, state IDLE; cmd_ready=0 during rst, 1 after; alu_a/alu_b=0,
//   alu_sel=4'b0000; rsp_valid/rsp_data/rsp_carry/rsp_illegal/rsp_tag=0.
// - cmd accepted when cmd_valid&&cmd_ready; cmd_ready = !fifo_full (no bypass, no combo path
//   from rsp_ready). Push and pop in same cycle allowed; count unchanged.
// - FSM: IDLE -> DRIVE when FIFO non-empty: pop head, load alu_a/alu_b/alu_sel, hold tag.
//   DRIVE (1 cycle, ALU settles) -> HOLD: capture alu_out->rsp_data, masked carry, illegal
//   flag (op>3), tag; rsp_valid=1.
//   HOLD: payload stable while rsp_valid&&!rsp_ready. On rsp_ready: rsp_valid=0; if FIFO
//   non-empty pop next and go DRIVE directly, else IDLE.
// - alu_* outputs change only on a pop; they hold last command while IDLE/HOLD.
// - Latency: command pushed at edge t into empty FIFO, IDLE -> rsp_valid high after edge t+2.
//   Throughput with rsp_ready=1: one response per 2 cycles.
// - Capacity: DEPTH queued + 1 in flight; with rsp_ready=0, cmd_ready drops after DEPTH+1
//   accepts.
// - Responses strictly in command order; no drop, no duplicate.
// - Arithmetic done by ALU only; rsp_data is alu_out verbatim (mod 256 for add/sub).
// - FIFO pointers wrap modulo DEPTH; full/empty via count (0..DEPTH).
// - rst mid-operation: in-flight and queued commands discarded, no response emitted,
//   all outputs to reset values on next edge.
// TESTING
// - op 0000, A=8'hF0, B=8'h20, tag 3 -> rsp_data 8'h10, rsp_carry 1, rsp_tag 3, valid 2 cycles after accept.
// - op 0001, A=8'h05, B=8'h07 -> rsp_data 8'hFE, rsp_carry 0 (alu_carry masked), rsp_illegal 0.
// - op 0010 A=8'hCC B=8'hAA -> 8'h88; op 0011 same -> 8'h66; tags 1,2 returned in order.
// - rsp_ready=0, stream cmds: exactly DEPTH+1 (5) accepted then cmd_ready=0; release ->
//   5 responses in order, payload stable while stalled, cmd_ready reasserts after first pop.
// - op 4'b1010, A=8'h09, B=8'h03 -> rsp_data 8'h06, rsp_illegal 1, rsp_carry 0.
// - Assert rst in DRIVE with 2 queued -> next cycle rsp_valid=0, alu_sel=0, cmd_ready 1 after rst; no stale response.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives registered operands to a combinational ALU and
// returns tagged results in command order on a valid/ready response stream.
//
// state | meaning
// IDLE  | no command in flight; pop as soon as the queue is non-empty
// DRIVE | operands on alu_*, ALU settling for one cycle
// HOLD  | response presented; waits for rsp_ready, may chain the next pop
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [TAG_W-1:0]   tag_q;

    logic [3:0]         mem_op  [DEPTH];
    logic [7:0]         mem_a   [DEPTH];
    logic [7:0]         mem_b   [DEPTH];
    logic [TAG_W-1:0]   mem_tag [DEPTH];

    logic push;
    logic pop;

    assign cmd_ready = !rst && (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    // No bypass: a command pushed this cycle is popped no earlier than next cycle.
    assign pop       = (count != '0) &&
                       ((state == IDLE) || ((state == HOLD) && rsp_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= cmd_op;
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tag_q       <= '0;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            alu_sel     <= 4'h0;
            rsp_valid   <= 1'b0;
            rsp_data    <= 8'h00;
            rsp_carry   <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                alu_a   <= mem_a[rd_ptr];
                alu_b   <= mem_b[rd_ptr];
                alu_sel <= mem_op[rd_ptr];
                tag_q   <= mem_tag[rd_ptr];
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (pop) state <= DRIVE;
                end
                DRIVE: begin
                    rsp_data    <= alu_out;
                    rsp_carry   <= (alu_sel == 4'h0) && alu_carry;
                    rsp_illegal <= (alu_sel > 4'h3);
                    rsp_tag     <= tag_q;
                    rsp_valid   <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= pop ? DRIVE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: a behavioural ALU drives alu_out,
// and a queue-based reference model predicts every response in order.
module tb_alu_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_illegal;
    logic [3:0] rsp_tag;

    int checks = 0;
    int errors = 0;
    int n_fire = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       ill;
        logic [3:0] tag;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag)
    );

    always #5 clk = ~clk;

    // Combinational ALU the sequencer talks to.
    always_comb begin
        logic [8:0] sum;
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum[8];
        case (alu_sel)
            4'h0:    alu_out = sum[7:0];
            4'h2:    alu_out = alu_a & alu_b;
            4'h3:    alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a - alu_b;
        endcase
    end

    function automatic rsp_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [3:0] tag);
        rsp_t r;
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        case (op)
            4'h0:    r.data = 8'((ai + bi) % 256);
            4'h2:    r.data = a & b;
            4'h3:    r.data = a ^ b;
            default: r.data = 8'((ai - bi + 256) % 256);
        endcase
        r.carry = (op == 4'h0) && (ai + bi > 255);
        r.ill   = (int'(op) > 3);
        r.tag   = tag;
        return r;
    endfunction

    // Scoreboard: predict on accept, compare on response handshake.
    always @(negedge clk) begin
        rsp_t got;
        rsp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                got = {rsp_data, rsp_carry, rsp_illegal, rsp_tag};
                got_q.push_back(got);
                n_fire++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_extra: got data=%h tag=%0d, none expected", rsp_data, rsp_tag);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got data=%h c=%b ill=%b tag=%0d, expected data=%h c=%b ill=%b tag=%0d",
                                 got.data, got.carry, got.ill, got.tag, e.data, e.carry, e.ill, e.tag);
                    end
                end
            end
            if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_tag));
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_tag = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_sel !== 4'h0 || alu_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: cmd_ready=%b rsp_valid=%b alu_sel=%h alu_a=%h, required 0/0/0/00",
                     cmd_ready, rsp_valid, alu_sel, alu_a);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_data !== 8'h00 || rsp_tag !== 4'h0 || rsp_carry !== 1'b0
            || rsp_illegal !== 1'b0 || alu_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b rsp_data=%h rsp_tag=%0d, required 1/00/0",
                     cmd_ready, rsp_data, rsp_tag);
        end
    endtask

    task automatic test_add_latency();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'hF0; cmd_b = 8'h20; cmd_tag = 4'd3;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_lat_t0: rsp_valid=%b, required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 8'hF0 || alu_b !== 8'h20 || alu_sel !== 4'h0) begin
            errors++;
            $display("FAIL add_lat_t1: rsp_valid=%b alu_a=%h alu_b=%h alu_sel=%h, required 0/f0/20/0",
                     rsp_valid, alu_a, alu_b, alu_sel);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 8'h10 || rsp_carry !== 1'b1 || rsp_tag !== 4'd3
            || rsp_illegal !== 1'b0) begin
            errors++;
            $display("FAIL add_result: valid=%b data=%h carry=%b tag=%0d ill=%b, required 1/10/1/3/0",
                     rsp_valid, rsp_data, rsp_carry, rsp_tag, rsp_illegal);
        end
        pulse_ready();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_consumed: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_sub();
        bit ok;
        send(4'h1, 8'h05, 8'h07, 4'd9);
        wait_valid(ok);
        checks++;
        if (!ok || rsp_data !== 8'hFE || rsp_carry !== 1'b0 || rsp_illegal !== 1'b0 || rsp_tag !== 4'd9) begin
            errors++;
            $display("FAIL sub_result: valid=%b data=%h carry=%b ill=%b tag=%0d, required 1/fe/0/0/9",
                     ok, rsp_data, rsp_carry, rsp_illegal, rsp_tag);
        end
        pulse_ready();
    endtask

    task automatic test_and_xor();
        got_q.delete();
        rsp_ready = 1'b1;
        send(4'h2, 8'hCC, 8'hAA, 4'd1);
        send(4'h3, 8'hCC, 8'hAA, 4'd2);
        for (int i = 0; i < 20 && got_q.size() < 2; i++) @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL and_xor_count: got %0d responses, required 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0].data !== 8'h88 || got_q[0].tag !== 4'd1 || got_q[1].data !== 8'h66 || got_q[1].tag !== 4'd2) begin
                errors++;
                $display("FAIL and_xor_order: got %h/%0d %h/%0d, required 88/1 66/2",
                         got_q[0].data, got_q[0].tag, got_q[1].data, got_q[1].tag);
            end
        end
    endtask

    task automatic test_capacity();
        int acc;
        logic [7:0] snap_d;
        logic [3:0] snap_t;
        got_q.delete();
        acc = 0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'(acc % 4); cmd_a = 8'(8'h31 * (acc + 1)); cmd_b = 8'h17; cmd_tag = 4'(8 + acc);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cmd_ready) acc++;
            @(posedge clk); #1;
            cmd_op = 4'(acc % 4); cmd_a = 8'(8'h31 * (acc + 1)); cmd_b = 8'h17; cmd_tag = 4'(8 + acc);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (acc != 5 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL capacity: accepted %0d cmd_ready=%b, required 5/0", acc, cmd_ready);
        end
        snap_d = rsp_data;
        snap_t = rsp_tag;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_tag !== snap_t || snap_t !== 4'd8) begin
            errors++;
            $display("FAIL stall_stable: valid=%b data=%h tag=%0d, required 1/%h/8",
                     rsp_valid, rsp_data, rsp_tag, snap_d);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_reassert: cmd_ready=%b, required 1", cmd_ready);
        end
        for (int i = 0; i < 40 && got_q.size() < 5; i++) @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (got_q.size() != 5) begin
            errors++;
            $display("FAIL drain_count: got %0d responses, required 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i].tag !== 4'(8 + i)) begin
                    errors++;
                    $display("FAIL drain_order: response %0d tag=%0d, required %0d", i, got_q[i].tag, 8 + i);
                end
            end
        end
    endtask

    task automatic test_illegal();
        bit ok;
        send(4'hA, 8'h09, 8'h03, 4'd5);
        wait_valid(ok);
        checks++;
        if (!ok || rsp_data !== 8'h06 || rsp_illegal !== 1'b1 || rsp_carry !== 1'b0 || rsp_tag !== 4'd5) begin
            errors++;
            $display("FAIL illegal_op: valid=%b data=%h ill=%b carry=%b tag=%0d, required 1/06/1/0/5",
                     ok, rsp_data, rsp_illegal, rsp_carry, rsp_tag);
        end
        pulse_ready();
    endtask

    task automatic test_random();
        int start;
        bit done;
        int cyc;
        start = n_fire;
        done = 1'b0;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    send(($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3)),
                         8'($urandom), 8'($urandom), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!(done && exp_q.size() == 0 && !rsp_valid) && cyc < 3000) begin
                    @(posedge clk); #1 rsp_ready = ($urandom_range(0, 3) != 0);
                    cyc++;
                end
                rsp_ready = 1'b0;
            end
        join
        checks++;
        if (n_fire - start != 60 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: %0d responses, %0d pending, required 60/0", n_fire - start, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int start;
        rsp_ready = 1'b0;
        send(4'h1, 8'h40, 8'h01, 4'd0);
        wait_valid(ok);
        send(4'h3, 8'h5A, 8'h0F, 4'd1);
        send(4'h2, 8'h11, 8'h22, 4'd2);
        send(4'h0, 8'h33, 8'h44, 4'd3);
        pulse_ready();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || rsp_valid !== 1'b0 || alu_sel !== 4'h3 || alu_a !== 8'h5A) begin
            errors++;
            $display("FAIL pre_rst_drive: valid=%b alu_sel=%h alu_a=%h, required 0/3/5a", rsp_valid, alu_sel, alu_a);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_sel !== 4'h0 || alu_a !== 8'h00 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: valid=%b alu_sel=%h alu_a=%h cmd_ready=%b, required 0/0/00/0",
                     rsp_valid, alu_sel, alu_a, cmd_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        start = n_fire;
        ok = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (ok || n_fire != start) begin
            errors++;
            $display("FAIL stale_rsp: saw rsp_valid=%b responses=%0d, required 0/0", ok, n_fire - start);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub();
        test_and_xor();
        test_capacity();
        test_illegal();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
